// File: rtl/alu_share_arb.sv
// alu_share_arb: two requesters share one 32-bit ALU through a 3-state
// accept / execute / respond sequencer with fixed or round-robin arbitration.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   reqN_valid_in / reqN_ready_o    requester N handshake (N = 0, 1)
//   reqN_a_in, reqN_b_in            requester N operands
//   reqN_op_in                      ALU control (000 add, 001 sub, 010 and,
//                                   011 or, 101 slt, others give 0)
//   rsp_valid_o / rsp_ready_in      response handshake
//   rsp_id_o                        requester the response belongs to
//   rsp_result_o, rsp_flags_o       ALU result and flags {Z,N,V,C}
//   ops_count_o                     completed responses, wraps at 2^16

module alu_core (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] result,
    output logic [3:0]  flags
);
    logic        is_arith;
    logic        is_and;
    logic        is_or;
    logic        is_slt;
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic        v;
    logic        c;

    assign is_arith = (op[2:1] == 2'b00);
    assign is_and   = (op == 3'b010);
    assign is_or    = (op == 3'b011);
    assign is_slt   = (op == 3'b101);

    // Subtract is A + ~B + 1, so carry means "no borrow".
    assign b_eff = op[0] ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {32'd0, op[0]};

    always_comb begin
        result = '0;
        unique case (1'b1)
            is_arith: result = sum[31:0];
            is_and:   result = a & b;
            is_or:    result = a | b;
            is_slt:   result = {31'd0, $signed(a) < $signed(b)};
            default:  result = '0;
        endcase
    end

    // Overflow: both addends share a sign that the sum does not.
    assign v = is_arith & (a[31] == b_eff[31]) & (sum[31] != a[31]);
    assign c = is_arith & sum[32];

    assign flags = {result == '0, result[31], v, c};
endmodule

module alu_share_arb #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid_in,
    output logic        req0_ready_o,
    input  logic [31:0] req0_a_in,
    input  logic [31:0] req0_b_in,
    input  logic [2:0]  req0_op_in,
    input  logic        req1_valid_in,
    output logic        req1_ready_o,
    input  logic [31:0] req1_a_in,
    input  logic [31:0] req1_b_in,
    input  logic [2:0]  req1_op_in,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_in,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,
    output logic [3:0]  rsp_flags_o,
    output logic [15:0] ops_count_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        last_grant_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  op_q;
    logic        id_q;
    logic        rsp_id_q;
    logic [31:0] rsp_result_q;
    logic [3:0]  rsp_flags_q;
    logic [15:0] ops_count_q;

    logic        any_valid;
    logic        win;
    logic        accept;
    logic        rsp_done;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;

    assign any_valid = req0_valid_in | req1_valid_in;
    assign accept    = (state_q == IDLE) & any_valid;
    assign rsp_done  = (state_q == RESP) & rsp_ready_in;

    // Winner id; on a tie round-robin favours whoever lost last time.
    always_comb begin
        win = 1'b0;
        if (req0_valid_in && req1_valid_in)
            win = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        else
            win = ~req0_valid_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready_o = accept & ~win;
        req1_ready_o = accept & win;
        rsp_valid_o  = (state_q == RESP);
        rsp_id_o     = rsp_id_q;
        rsp_result_o = rsp_result_q;
        rsp_flags_o  = rsp_flags_q;
        ops_count_o  = ops_count_q;
    end

    alu_core u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            ops_count_q  <= '0;
        end else begin
            if (accept) begin
                a_q          <= win ? req1_a_in : req0_a_in;
                b_q          <= win ? req1_b_in : req0_b_in;
                op_q         <= win ? req1_op_in : req0_op_in;
                id_q         <= win;
                last_grant_q <= win;
            end
            if (state_q == EXEC) begin
                rsp_id_q     <= id_q;
                rsp_result_q <= alu_result;
                rsp_flags_q  <= alu_flags;
            end
            if (rsp_done)
                ops_count_q <= ops_count_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: round-robin and fixed-priority instances on shared
// stimulus, reference model feeding a scoreboard drained by a monitor.

module tb_alu_share_arb;
    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic [31:0] a0 = '0;
    logic [31:0] b0 = '0;
    logic [31:0] a1 = '0;
    logic [31:0] b1 = '0;
    logic [2:0]  op0 = '0;
    logic [2:0]  op1 = '0;
    logic        rsp_rdy = 1'b0;

    logic [1:0]       rdy0;
    logic [1:0]       rdy1;
    logic [1:0]       rv;
    logic [1:0]       rid;
    logic [1:0][31:0] rres;
    logic [1:0][3:0]  rfl;
    logic [1:0][15:0] cnt;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   m_phase[2];
    logic m_last[2];
    int   m_count[2];
    logic m_w;
    logic m_any;
    logic hold_v[2];
    exp_t hold_e[2];
    exp_t mon_e;
    int   mon_sz;

    always #5 clk = ~clk;

    alu_share_arb #(.FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_in(v0), .req0_ready_o(rdy0[0]),
        .req0_a_in(a0), .req0_b_in(b0), .req0_op_in(op0),
        .req1_valid_in(v1), .req1_ready_o(rdy1[0]),
        .req1_a_in(a1), .req1_b_in(b1), .req1_op_in(op1),
        .rsp_valid_o(rv[0]), .rsp_ready_in(rsp_rdy),
        .rsp_id_o(rid[0]), .rsp_result_o(rres[0]),
        .rsp_flags_o(rfl[0]), .ops_count_o(cnt[0])
    );

    alu_share_arb #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_in(v0), .req0_ready_o(rdy0[1]),
        .req0_a_in(a0), .req0_b_in(b0), .req0_op_in(op0),
        .req1_valid_in(v1), .req1_ready_o(rdy1[1]),
        .req1_a_in(a1), .req1_b_in(b1), .req1_op_in(op1),
        .rsp_valid_o(rv[1]), .rsp_ready_in(rsp_rdy),
        .rsp_id_o(rid[1]), .rsp_result_o(rres[1]),
        .rsp_flags_o(rfl[1]), .ops_count_o(cnt[1])
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference ALU from arithmetic definitions: carry as an unsigned
    // overflow / no-borrow test, V as the signed result leaving 32-bit range.
    function automatic exp_t ref_alu(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] op, input logic id);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      s;
        logic [31:0] r;
        logic        c;
        logic        v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                r = a + b;
                c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        e.id  = id;
        e.res = r;
        e.fl  = {r == 32'd0, r[31], v, c};
        return e;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Reference model: d=0 round-robin, d=1 fixed priority.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_phase[d] = 0;
                m_last[d]  = 1'b1;
                m_count[d] = 0;
                if (d == 0) q0.delete();
                else q1.delete();
                chk($sformatf("rst_rv%0d", d), rv[d], 0);
                chk($sformatf("rst_cnt%0d", d), cnt[d], 0);
                chk($sformatf("rst_res%0d", d), {rid[d], rfl[d], rres[d]}, 0);
            end else begin
                chk($sformatf("cnt%0d", d), cnt[d], m_count[d]);
                chk($sformatf("rv%0d", d), rv[d], m_phase[d] == 2);
                if (m_phase[d] == 0) begin
                    m_any = v0 | v1;
                    if (v0 && v1)
                        m_w = (d == 1) ? 1'b0 : ~m_last[d];
                    else
                        m_w = ~v0;
                    chk($sformatf("rdy0_%0d", d), rdy0[d], m_any & ~m_w);
                    chk($sformatf("rdy1_%0d", d), rdy1[d], m_any & m_w);
                    if (m_any) begin
                        if (d == 0)
                            q0.push_back(m_w ? ref_alu(a1, b1, op1, 1'b1)
                                             : ref_alu(a0, b0, op0, 1'b0));
                        else
                            q1.push_back(m_w ? ref_alu(a1, b1, op1, 1'b1)
                                             : ref_alu(a0, b0, op0, 1'b0));
                        m_last[d]  = m_w;
                        m_phase[d] = 1;
                    end
                end else begin
                    chk($sformatf("busy_rdy%0d", d), {rdy0[d], rdy1[d]}, 0);
                    if (m_phase[d] == 1)
                        m_phase[d] = 2;
                    else if (rsp_rdy) begin
                        m_phase[d] = 0;
                        m_count[d] = (m_count[d] + 1) & 16'hFFFF;
                    end
                end
            end
        end
    end

    // Monitor: checks held responses stay stable and pops on each handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n && rv[d]) begin
                if (hold_v[d])
                    chk($sformatf("stable%0d", d),
                        {rid[d], rres[d], rfl[d]}, hold_e[d]);
                if (rsp_rdy) begin
                    mon_sz = (d == 0) ? q0.size() : q1.size();
                    chk($sformatf("sb_nonempty%0d", d), mon_sz != 0, 1);
                    if (mon_sz != 0) begin
                        mon_e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("sb_id%0d", d), rid[d], mon_e.id);
                        chk($sformatf("sb_res%0d", d), rres[d], mon_e.res);
                        chk($sformatf("sb_fl%0d", d), rfl[d], mon_e.fl);
                    end
                    hold_v[d] = 1'b0;
                end else begin
                    hold_v[d] = 1'b1;
                    hold_e[d] = {rid[d], rres[d], rfl[d]};
                end
            end else begin
                hold_v[d] = 1'b0;
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input string nm, input logic id,
                              input logic [31:0] res, input logic [3:0] fl);
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rv[0]) seen = 1'b1;
        end
        chk({nm, "_seen"}, seen, 1);
        if (seen) begin
            chk({nm, "_id"}, rid[0], id);
            chk({nm, "_res"}, rres[0], res);
            chk({nm, "_fl"}, rfl[0], fl);
        end
    endtask

    initial begin
        bit seen;
        hold_v[0] = 1'b0;
        hold_v[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset while in EXEC discards the transaction.
        a0 = 32'd7; b0 = 32'd9; op0 = 3'd0; v0 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (rdy0[0]) seen = 1'b1;
        end
        chk("exec_rst_accept", seen, 1);
        drive_edge();
        v0 = 1'b0;
        rst_n = 1'b0;
        drive_edge();
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("exec_rst_rv", rv[0], 0);
            chk("exec_rst_cnt", cnt[0], 0);
        end

        // Tie after reset goes to req0, then alternates.
        drive_edge();
        rsp_rdy = 1'b1;
        a0 = 32'd5; b0 = 32'd3; op0 = 3'd0; v0 = 1'b1;
        a1 = 32'd5; b1 = 32'd5; op1 = 3'd1; v1 = 1'b1;
        @(negedge clk);
        chk("tie_rdy0", rdy0[0], 1);
        chk("tie_rdy1", rdy1[0], 0);
        expect_rsp("add53", 1'b0, 32'd8, 4'b0000);
        @(negedge clk);
        chk("cnt_after_first", cnt[0], 1);
        expect_rsp("sub55", 1'b1, 32'd0, 4'b1001);
        drive_edge();
        a1 = 32'd3; b1 = 32'd5;
        expect_rsp("rr_0a", 1'b0, 32'd8, 4'b0000);
        expect_rsp("sub35", 1'b1, 32'hFFFF_FFFE, 4'b0100);
        drive_edge();
        a1 = 32'h8000_0000; b1 = 32'd1;
        expect_rsp("rr_0b", 1'b0, 32'd8, 4'b0000);
        expect_rsp("sub_ovf", 1'b1, 32'h7FFF_FFFF, 4'b0011);
        drive_edge();
        v0 = 1'b0;
        v1 = 1'b0;
        repeat (4) drive_edge();

        // Response held for 5 cycles with both requesters waiting.
        rsp_rdy = 1'b0;
        a0 = 32'h0000_F0F0; b0 = 32'h0000_FF00; op0 = 3'd2; v0 = 1'b1;
        expect_rsp("and_hold", 1'b0, 32'h0000_F000, 4'b0000);
        drive_edge();
        v1 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_rv", rv[0], 1);
            chk("hold_rdy", {rdy0[0], rdy1[0]}, 0);
            chk("hold_cnt", cnt[0], 6);
        end
        drive_edge();
        rsp_rdy = 1'b1;
        @(negedge clk);
        chk("hs_cnt_before", cnt[0], 6);
        @(negedge clk);
        chk("hs_cnt_after", cnt[0], 7);
        drive_edge();
        v0 = 1'b0;
        v1 = 1'b0;
        repeat (4) drive_edge();

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            drive_edge();
            rst_n   = ($urandom_range(0, 299) != 0);
            v0      = ($urandom_range(0, 2) != 0);
            v1      = ($urandom_range(0, 2) != 0);
            a0      = rnd32();
            b0      = rnd32();
            a1      = rnd32();
            b1      = rnd32();
            op0     = 3'($urandom_range(0, 7));
            op1     = 3'($urandom_range(0, 7));
            rsp_rdy = ($urandom_range(0, 3) != 0);
        end

        drive_edge();
        rst_n = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        rsp_rdy = 1'b1;
        repeat (6) drive_edge();
        @(negedge clk);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
